// File: rtl/hist_eq_lut.sv
// Histogram-equalisation LUT builder: reads a finished histogram, forms the CDF,
// divides it into a double-buffered 256x8 mapping LUT and remaps luma through it.
module hist_eq_lut #(
   parameter int BIN_W = 16,
   parameter int CDF_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [7:0]       hist_rd_addr,
   input  logic [BIN_W-1:0] hist_rd_data,
   output logic             busy,
   output logic             done,
   output logic             lut_valid,
   input  logic [7:0]       pix_in,
   input  logic             pix_in_valid,
   output logic [7:0]       pix_out,
   output logic             pix_out_valid
);

   typedef enum logic [2:0] {IDLE, SUM, SCAN, DIV, WR, COMMIT} state_t;

   state_t             state, state_nx;
   logic [8:0]         cnt;
   logic [7:0]         idx;
   logic [CDF_W-1:0]   total, cdf, cdf_min;
   logic [CDF_W+7:0]   rem, dsh;
   logic [7:0]         q;
   logic [2:0]         bitn;
   logic               seen_nz, multi, active;

   logic [7:0]         lut0 [256];
   logic [7:0]         lut1 [256];

   logic [CDF_W-1:0]   bin_ext, cdf_nx, min_nx, den_c;
   logic [CDF_W+7:0]   num_c;
   logic               degen;

   // Fewer than two non-zero bins means total - cdf_min ends up 0: identity map.
   assign degen = ~multi;

   always_comb begin
      bin_ext = CDF_W'(hist_rd_data);
      cdf_nx  = cdf + bin_ext;
      min_nx  = (cdf_min == '0 && bin_ext != '0) ? bin_ext : cdf_min;
      num_c   = (CDF_W+8)'(cdf_nx - min_nx) * (CDF_W+8)'(255);
      den_c   = total - min_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      done     = (state == COMMIT);
      case (state)
         IDLE:    if (start) state_nx = SUM;
         SUM:     if (cnt == 9'd256) state_nx = SCAN;
         SCAN:    state_nx = degen ? WR : DIV;
         DIV:     if (bitn == 3'd0) state_nx = WR;
         WR:      state_nx = (idx == 8'd255) ? COMMIT : SCAN;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // hist_rd_addr runs one bin ahead so each SCAN cycle sees its bin's data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         idx          <= '0;
         hist_rd_addr <= '0;
         total        <= '0;
         cdf          <= '0;
         cdf_min      <= '0;
         rem          <= '0;
         dsh          <= '0;
         q            <= '0;
         bitn         <= '0;
         seen_nz      <= 1'b0;
         multi        <= 1'b0;
         active       <= 1'b0;
         lut_valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt          <= '0;
               hist_rd_addr <= '0;
               total        <= '0;
               seen_nz      <= 1'b0;
               multi        <= 1'b0;
            end
            SUM: begin
               cnt <= cnt + 9'd1;
               if (cnt != 9'd256) hist_rd_addr <= hist_rd_addr + 8'd1;
               if (cnt != 9'd0) begin
                  total <= total + bin_ext;
                  if (bin_ext != '0) begin
                     if (seen_nz) multi <= 1'b1;
                     seen_nz <= 1'b1;
                  end
               end
               if (cnt == 9'd256) begin
                  cdf     <= '0;
                  cdf_min <= '0;
                  idx     <= '0;
               end
            end
            SCAN: begin
               cdf     <= cdf_nx;
               cdf_min <= min_nx;
               rem     <= num_c;
               dsh     <= (CDF_W+8)'(den_c) << 7;
               bitn    <= 3'd7;
               if (degen) begin
                  q            <= idx;
                  hist_rd_addr <= idx + 8'd1;
               end else begin
                  q <= '0;
               end
            end
            DIV: begin
               if (rem >= dsh) begin
                  rem     <= rem - dsh;
                  q[bitn] <= 1'b1;
               end
               dsh  <= dsh >> 1;
               bitn <= bitn - 3'd1;
               if (bitn == 3'd0) hist_rd_addr <= idx + 8'd1;
            end
            WR: idx <= idx + 8'd1;
            COMMIT: begin
               active    <= ~active;
               lut_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == WR) begin
         if (active) lut0[idx] <= q;
         else        lut1[idx] <= q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_out       <= '0;
         pix_out_valid <= 1'b0;
      end else begin
         pix_out_valid <= pix_in_valid;
         if (pix_in_valid) begin
            if (!lut_valid)  pix_out <= pix_in;
            else if (active) pix_out <= lut1[pix_in];
            else             pix_out <= lut0[pix_in];
         end
      end
   end

endmodule

// File: tb/tb_hist_eq_lut.sv
// Directed bench for hist_eq_lut: histogram memory model with 1-cycle read latency,
// LUT contents checked through the pixel path.
module tb_hist_eq_lut;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  hist_rd_addr;
   logic [15:0] hist_rd_data = '0;
   logic        busy, done, lut_valid;
   logic [7:0]  pix_in = '0;
   logic        pix_in_valid = 1'b0;
   logic [7:0]  pix_out;
   logic        pix_out_valid;

   logic [15:0] hist [256];
   int          total = 0;
   int          bad = 0;
   int          n;
   int          dcount;

   hist_eq_lut #(.BIN_W(16), .CDF_W(24)) dut (
      .clk(clk), .rst(rst), .start(start),
      .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
      .busy(busy), .done(done), .lut_valid(lut_valid),
      .pix_in(pix_in), .pix_in_valid(pix_in_valid),
      .pix_out(pix_out), .pix_out_valid(pix_out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) hist_rd_data <= hist[hist_rd_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_hist();
      for (int i = 0; i < 256; i++) hist[i] = '0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic after_done();
      @(negedge clk);
      chk("lut_valid_after", {31'd0, lut_valid}, 32'd1);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   task automatic pix(input string tag, input logic [7:0] p, input logic [7:0] e);
      @(negedge clk);
      pix_in = p;
      pix_in_valid = 1'b1;
      @(negedge clk);
      pix_in_valid = 1'b0;
      chk(tag, {24'd0, pix_out}, {24'd0, e});
      chk({tag, "_v"}, {31'd0, pix_out_valid}, 32'd1);
   endtask

   initial begin
      clr_hist();
      repeat (3) @(negedge clk);
      chk("rst_addr", {24'd0, hist_rd_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_lut_valid", {31'd0, lut_valid}, 32'd0);
      chk("rst_pix_out", {24'd0, pix_out}, 32'd0);
      chk("rst_pix_out_valid", {31'd0, pix_out_valid}, 32'd0);
      rst = 1'b0;

      pix("bypass_37", 8'h37, 8'h37);
      chk("bypass_lut_valid", {31'd0, lut_valid}, 32'd0);

      // Uniform histogram: formula yields identity.
      for (int i = 0; i < 256; i++) hist[i] = 16'd1;
      pulse_start();
      chk("busy_during", {31'd0, busy}, 32'd1);
      wait_done(3340, n);
      after_done();
      pix("flat_00", 8'h00, 8'h00);
      pix("flat_a5", 8'hA5, 8'hA5);
      pix("flat_ff", 8'hFF, 8'hFF);

      // Bins 0..3 = 1: den 3.
      clr_hist();
      for (int i = 0; i < 4; i++) hist[i] = 16'd1;
      pulse_start();
      wait_done(3340, n);
      after_done();
      pix("four_0", 8'd0, 8'd0);
      pix("four_1", 8'd1, 8'd85);
      pix("four_2", 8'd2, 8'd170);
      pix("four_3", 8'd3, 8'd255);
      pix("four_200", 8'd200, 8'd255);

      // Bins 100,200 = 128; pixel 150 straddles the bank swap (old 255, new 0).
      clr_hist();
      hist[100] = 16'd128;
      hist[200] = 16'd128;
      pulse_start();
      wait_done(3340, n);
      pix_in = 8'd150;
      pix_in_valid = 1'b1;
      @(negedge clk);
      chk("swap_old_bank", {24'd0, pix_out}, 32'd255);
      @(negedge clk);
      pix_in_valid = 1'b0;
      chk("swap_new_bank", {24'd0, pix_out}, 32'd0);
      pix("two_50", 8'd50, 8'd0);
      pix("two_100", 8'd100, 8'd0);
      pix("two_200", 8'd200, 8'd255);

      // All-zero histogram, with an extra start while busy.
      clr_hist();
      pulse_start();
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(3340, n);
      chk("zero_no_restart", {31'd0, (n < 700)}, 32'd1);
      after_done();
      dcount = 0;
      repeat (50) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dcount++;
      end
      chk("zero_single_done", dcount, 32'd0);
      pix("zero_10", 8'h10, 8'h10);
      pix("zero_c3", 8'hC3, 8'hC3);

      // Single non-zero bin.
      clr_hist();
      hist[50] = 16'd400;
      pulse_start();
      wait_done(3340, n);
      after_done();
      pix("single_05", 8'h05, 8'h05);
      pix("single_32", 8'h32, 8'h32);
      pix("single_ee", 8'hEE, 8'hEE);

      // Reset in the middle of a DIV phase.
      for (int i = 0; i < 256; i++) hist[i] = 16'd1;
      pulse_start();
      repeat (300) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_lut_valid", {31'd0, lut_valid}, 32'd0);
      pix("abort_bypass", 8'h5A, 8'h5A);

      clr_hist();
      for (int i = 0; i < 4; i++) hist[i] = 16'd1;
      pulse_start();
      wait_done(3340, n);
      after_done();
      pix("rebuild_0", 8'd0, 8'd0);
      pix("rebuild_2", 8'd2, 8'd170);
      pix("rebuild_9", 8'd9, 8'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hist_eq_lut.md
Name: hist_eq_lut

Overview:
- Downstream consumer of the histogram calculator.
- After a frame's histogram is complete, it reads all 256 bins over the histogram's external read port and computes the CDF.
- It builds a 256-entry histogram-equalisation mapping LUT, then remaps incoming 8-bit luma pixels through it.
- The LUT is double-buffered: the next frame's LUT is built while the current one is in use.

Parameters:
- BIN_W, 16, width of one histogram bin (matches the histogram read-data width).
- CDF_W, 24, width of the CDF/total accumulators; must satisfy CDF_W ≥ BIN_W + 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse: histogram ready, build a new LUT.
- hist_rd_addr  out  8  bin address to the histogram read port.
- hist_rd_data  in  BIN_W  bin count; valid exactly 1 cycle after hist_rd_addr.
- busy  out  1  high while a build is in progress.
- done  out  1  one-cycle pulse: new LUT committed.
- lut_valid  out  1  at least one LUT committed since reset.
- pix_in  in  8  input pixel.
- pix_in_valid  in  1  pix_in qualifier.
- pix_out  out  8  remapped pixel.
- pix_out_valid  out  1  pix_out qualifier.

Behaviour:
- Reset values: hist_rd_addr=0, busy=0, done=0, lut_valid=0, pix_out=0, pix_out_valid=0; FSM=IDLE; active bank=0.
- Reset mid-build aborts the build immediately. The build's write bank is never committed.
- FSM states: IDLE, SUM, SCAN, DIV, WR, COMMIT.
- IDLE: start=1 → SUM with addr=0, total=0, busy=1.
- start while busy=1 is ignored and has no effect.
- SUM (pass 1):
  - Issue addresses 0..255 on consecutive cycles.
  - Accumulate total += hist_rd_data, respecting the 1-cycle read latency.
  - After bin 255's data is accumulated, go to SCAN with cdf=0 and cdf_min=0.
- SCAN (pass 2): bins are read one at a time. For each bin i:
  - cdf += bin.
  - If cdf_min==0 and bin≠0, then cdf_min = bin.
  - Compute num = (cdf − cdf_min)·255 (width CDF_W+8) and den = total − cdf_min.
  - Go to DIV.
- DIV:
  - 8-iteration restoring divider, one quotient bit per cycle, MSB first. The quotient is always ≤255, so 8 bits suffice.
  - Result q = floor(num/den).
- WR:
  - Write q to write-bank entry i.
  - If i==255 go to COMMIT; otherwise i+1 and back to SCAN.
- Degenerate case: if den==0 (total==0, or all pixels in one bin), the FSM skips DIV and writes identity (entry i = i) for every bin.
- Bins below the first non-zero bin map to 0 (cdf − cdf_min = 0).
- Arithmetic is unsigned. total and cdf never overflow for CDF_W ≥ BIN_W + 8.
- COMMIT:
  - Toggle the active bank; done=1 for one cycle; lut_valid=1; busy=0; → IDLE.
  - A full build takes ≤ 257 + 256·12 + 4 cycles.
- Pixel path:
  - Latency is exactly 1 cycle: pix_out_valid(t+1) = pix_in_valid(t).
  - pix_out(t+1) = lut_active[pix_in(t)] when lut_valid=1, else pix_in(t) (bypass).
  - pix_out holds its last value when valid is low.
- Bank swap: pixels sampled in the same cycle as done use the old bank; pixels from the next cycle onward use the new bank.
- The pixel path runs continuously and independently of the FSM; a build never stalls it.
- Each bank is a 256×8 single-write, single-read array.

Test Plan:
- Reset, then pix_in=0x37 with pix_in_valid → 1 cycle later pix_out=0x37, pix_out_valid=1, lut_valid=0 (bypass).
- All 256 bins =1, start → done within 3340 cycles, lut_valid=1; pix_in 0x00/0xA5/0xFF → 0x00/0xA5/0xFF (identity from formula).
- Bins 0..3 =1, others 0 (total 4, cdf_min 1, den 3) → LUT[0]=0, LUT[1]=85, LUT[2]=170, LUT[3]=255, LUT[200]=255.
- Bins 100 and 200 =128 each, others 0 → LUT[50]=0, LUT[100]=0, LUT[150]=0, LUT[200]=255; swap boundary check: pixel in the done cycle uses the old LUT, the next pixel uses the new one.
- Degenerate inputs: all-zero histogram, and single bin 50 = 400 → identity LUT, done pulses once each; start pulsed during busy → no restart and exactly one done.
- rst asserted mid-DIV of the second build → busy=0, lut_valid=0, pixels bypass next cycle; a subsequent start completes normally.
